serdes_channel_rst: RTL and testbench

Per-channel GT reset sequencer, downstream of the QPLL common block. It consumes the QPLL lock and reset-done indications and sequences the GT TX and RX datapath resets (gttxreset/txuserrdy, gtrxreset/rxuserrdy). TX and RX run as independent state machines, each with a done-timeout and retry count. Its state is exported for the CPU status registers.

---
 rtl/serdes_channel_rst.sv | 168 ++++++++++++++++
 tb/tb_serdes_channel_rst.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_channel_rst.sv
// serdes_channel_rst: per-channel GT TX/RX reset sequencer with timeout retry and CDR-loss restart
module serdes_rst_fsm #(
  parameter int C_RST_PULSE_CYC = 16,
  parameter int C_WAIT_DONE_CYC = 200000,
  parameter int C_CDR_LOSS_CYC = 1024,
  parameter bit C_IS_RX = 1'b0
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_pll_ready,
  input  logic       I_force,
  input  logic       I_userclk_s,
  input  logic       I_resetdone_s,
  input  logic       I_cdrlock_s,
  output logic       O_gtreset,
  output logic       O_userrdy,
  output logic       O_done,
  output logic [2:0] O_state,
  output logic [7:0] O_retry_cnt
);
  typedef enum logic [2:0] {IDLE, ASSERT_RST, WAIT_USRCLK, USERRDY, DONE} state_e;
  localparam logic [23:0] PULSE_LAST = 24'(C_RST_PULSE_CYC - 1);
  localparam logic [23:0] WAIT_LAST = 24'(C_WAIT_DONE_CYC - 1);
  localparam logic [23:0] CDR_LAST = 24'(C_CDR_LOSS_CYC - 1);
  state_e state_q, state_d;
  logic [23:0] tmr_q, tmr_d;
  logic [7:0] retry_q, retry_d;
  logic gtreset_q, gtreset_d, userrdy_q, userrdy_d, done_q, done_d;
  logic fault, cdr_loss;
  assign cdr_loss = C_IS_RX && !I_cdrlock_s;
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q;
    fault = 1'b0;
    case (state_q)
      IDLE: state_d = I_pll_ready ? ASSERT_RST : IDLE;
      ASSERT_RST: begin
        if (tmr_q == '0) state_d = WAIT_USRCLK;
        else tmr_d = tmr_q - 24'd1;
      end
      WAIT_USRCLK: state_d = I_userclk_s ? USERRDY : WAIT_USRCLK;
      USERRDY: begin
        if (I_resetdone_s) state_d = DONE;
        else if (tmr_q == WAIT_LAST) begin
          state_d = ASSERT_RST;
          fault = 1'b1;
        end else tmr_d = tmr_q + 24'd1;
      end
      DONE: begin
        if (cdr_loss && tmr_q == CDR_LAST) begin
          state_d = ASSERT_RST;
          fault = 1'b1;
        end else if (!I_resetdone_s) state_d = ASSERT_RST;
        else tmr_d = cdr_loss ? tmr_q + 24'd1 : '0;
      end
      default: state_d = IDLE;
    endcase
    if (I_force) state_d = ASSERT_RST;
    if (!I_pll_ready || state_q > DONE) state_d = IDLE;
    if (state_d != state_q || (I_force && state_d == ASSERT_RST)) tmr_d = state_d == ASSERT_RST ? PULSE_LAST : '0;
    retry_d = retry_q + {7'd0, fault && I_pll_ready && !I_force && retry_q != 8'hff};
    gtreset_d = state_d == IDLE || state_d == ASSERT_RST;
    userrdy_d = state_d == USERRDY || state_d == DONE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= IDLE;
      tmr_q <= '0;
      retry_q <= '0;
      gtreset_q <= 1'b1;
      userrdy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      retry_q <= retry_d;
      gtreset_q <= gtreset_d;
      userrdy_q <= userrdy_d;
      done_q <= done_d;
    end
  end
  assign O_gtreset = gtreset_q;
  assign O_userrdy = userrdy_q;
  assign O_done = done_q;
  assign O_state = state_q;
  assign O_retry_cnt = retry_q;
endmodule

module serdes_channel_rst #(
  parameter int C_RST_PULSE_CYC = 16,
  parameter int C_WAIT_DONE_CYC = 200000,
  parameter int C_CDR_LOSS_CYC = 1024
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_qpll_lock,
  input  logic       I_qpll_resetdone,
  input  logic       I_force_txreset,
  input  logic       I_force_rxreset,
  input  logic       I_userclk_active,
  input  logic       I_txresetdone,
  input  logic       I_rxresetdone,
  input  logic       I_rxcdrlock,
  output logic       O_gttxreset,
  output logic       O_txuserrdy,
  output logic       O_gtrxreset,
  output logic       O_rxuserrdy,
  output logic [2:0] O_tx_rst_state,
  output logic [2:0] O_rx_rst_state,
  output logic       O_txresetdone,
  output logic       O_rxresetdone,
  output logic [7:0] O_tx_retry_cnt,
  output logic [7:0] O_rx_retry_cnt
);
  logic [4:0] meta_q, sync_q, sync_d;
  logic qpll_lock_s, userclk_active_s, txresetdone_s, rxresetdone_s, rxcdrlock_s, pll_ready;
  assign sync_d = {I_qpll_lock, I_userclk_active, I_txresetdone, I_rxresetdone, I_rxcdrlock};
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= sync_d;
      sync_q <= meta_q;
    end
  end
  assign {qpll_lock_s, userclk_active_s, txresetdone_s, rxresetdone_s, rxcdrlock_s} = sync_q;
  assign pll_ready = qpll_lock_s & I_qpll_resetdone;
  serdes_rst_fsm #(
    .C_RST_PULSE_CYC(C_RST_PULSE_CYC),
    .C_WAIT_DONE_CYC(C_WAIT_DONE_CYC),
    .C_CDR_LOSS_CYC(C_CDR_LOSS_CYC),
    .C_IS_RX(1'b0)
  ) u_tx (
    .I_clk(I_clk),
    .I_rst(I_rst),
    .I_pll_ready(pll_ready),
    .I_force(I_force_txreset),
    .I_userclk_s(userclk_active_s),
    .I_resetdone_s(txresetdone_s),
    .I_cdrlock_s(1'b1),
    .O_gtreset(O_gttxreset),
    .O_userrdy(O_txuserrdy),
    .O_done(O_txresetdone),
    .O_state(O_tx_rst_state),
    .O_retry_cnt(O_tx_retry_cnt)
  );
  serdes_rst_fsm #(
    .C_RST_PULSE_CYC(C_RST_PULSE_CYC),
    .C_WAIT_DONE_CYC(C_WAIT_DONE_CYC),
    .C_CDR_LOSS_CYC(C_CDR_LOSS_CYC),
    .C_IS_RX(1'b1)
  ) u_rx (
    .I_clk(I_clk),
    .I_rst(I_rst),
    .I_pll_ready(pll_ready),
    .I_force(I_force_rxreset),
    .I_userclk_s(userclk_active_s),
    .I_resetdone_s(rxresetdone_s),
    .I_cdrlock_s(rxcdrlock_s),
    .O_gtreset(O_gtrxreset),
    .O_userrdy(O_rxuserrdy),
    .O_done(O_rxresetdone),
    .O_state(O_rx_rst_state),
    .O_retry_cnt(O_rx_retry_cnt)
  );
endmodule

// File: tb/tb_serdes_channel_rst.sv
// tb_serdes_channel_rst: directed scoreboard bench for the GT reset sequencer
module tb_serdes_channel_rst;
  logic clk = 1'b0, rst = 1'b1, qpll_lock = 1'b0, qpll_resetdone = 1'b0;
  logic force_tx = 1'b0, force_rx = 1'b0, userclk = 1'b0, txrd = 1'b0, rxrd = 1'b0, cdr = 1'b0;
  logic gttx, txu, gtrx, rxu, txdone, rxdone;
  logic [2:0] tx_state, rx_state;
  logic [7:0] tx_retry, rx_retry;
  int total = 0, bad = 0, cyc = 0, n, t_prev;
  logic [2:0] q_tx[$], q_rx[$];
  logic [7:0] q_rr[$];
  logic [2:0] p_tx, p_rx;
  logic [7:0] p_rr;
  bit mon = 1'b0;
  serdes_channel_rst #(
    .C_RST_PULSE_CYC(16),
    .C_WAIT_DONE_CYC(100),
    .C_CDR_LOSS_CYC(1024)
  ) dut (
    .I_clk(clk),
    .I_rst(rst),
    .I_qpll_lock(qpll_lock),
    .I_qpll_resetdone(qpll_resetdone),
    .I_force_txreset(force_tx),
    .I_force_rxreset(force_rx),
    .I_userclk_active(userclk),
    .I_txresetdone(txrd),
    .I_rxresetdone(rxrd),
    .I_rxcdrlock(cdr),
    .O_gttxreset(gttx),
    .O_txuserrdy(txu),
    .O_gtrxreset(gtrx),
    .O_rxuserrdy(rxu),
    .O_tx_rst_state(tx_state),
    .O_rx_rst_state(rx_state),
    .O_txresetdone(txdone),
    .O_rxresetdone(rxdone),
    .O_tx_retry_cnt(tx_retry),
    .O_rx_retry_cnt(rx_retry)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic wait_st(input bit rx, input logic [2:0] s, input int lim, input string tag);
    int w = 0;
    while ((rx ? rx_state : tx_state) !== s && w < lim) begin
      tick(1);
      w++;
    end
    chk(tag, rx ? rx_state : tx_state, s);
  endtask
  always @(negedge clk) if (mon) begin
    if (tx_state !== p_tx) begin
      if (q_tx.size() == 0) chk("tx_state_unexpected", tx_state, p_tx);
      else chk("tx_state_seq", tx_state, q_tx.pop_front());
      p_tx = tx_state;
    end
    if (rx_state !== p_rx) begin
      if (q_rx.size() == 0) chk("rx_state_unexpected", rx_state, p_rx);
      else chk("rx_state_seq", rx_state, q_rx.pop_front());
      p_rx = rx_state;
    end
    if (rx_retry !== p_rr) begin
      if (q_rr.size() == 0) chk("rx_retry_unexpected", rx_retry, p_rr);
      else chk("rx_retry_seq", rx_retry, q_rr.pop_front());
      p_rr = rx_retry;
    end
  end
  initial begin
    tick(3);
    chk("rst_gttxreset", gttx, 1);
    chk("rst_gtrxreset", gtrx, 1);
    chk("rst_txuserrdy", txu, 0);
    chk("rst_rxuserrdy", rxu, 0);
    chk("rst_tx_state", tx_state, 0);
    chk("rst_rx_state", rx_state, 0);
    chk("rst_tx_retry", tx_retry, 0);
    chk("rst_rx_retry", rx_retry, 0);
    chk("rst_txdone", txdone, 0);
    chk("rst_rxdone", rxdone, 0);
    p_tx = tx_state;
    p_rx = rx_state;
    p_rr = rx_retry;
    mon = 1'b1;
    rst = 1'b0;
    tick(4);
    chk("idle_without_pll", tx_state, 0);
    // nominal TX bring-up; RX keeps rxresetdone low for the timeout test
    cdr = 1'b1;
    userclk = 1'b1;
    qpll_resetdone = 1'b1;
    qpll_lock = 1'b1;
    q_tx.push_back(1); q_tx.push_back(2); q_tx.push_back(3);
    q_rx.push_back(1); q_rx.push_back(2); q_rx.push_back(3);
    wait_st(0, 1, 10, "tx_enter_assert");
    n = 0;
    while (gttx === 1'b1 && n < 100) begin tick(1); n++; end
    chk("tx_rst_pulse_len", n, 16);
    chk("tx_wait_usrclk", tx_state, 2);
    chk("tx_userrdy_low_in_wait", txu, 0);
    tick(1);
    chk("tx_userrdy_state", tx_state, 3);
    chk("tx_userrdy_high", txu, 1);
    tick(30);
    q_tx.push_back(4);
    txrd = 1'b1;
    tick(2);
    chk("txdone_before_sync", txdone, 0);
    tick(1);
    chk("txdone_3cyc", txdone, 1);
    chk("tx_done_state", tx_state, 4);
    chk("tx_retry_nominal", tx_retry, 0);
    // RX timeout retries and saturation
    for (int i = 1; i <= 300; i++) begin
      q_rx.push_back(1); q_rx.push_back(2); q_rx.push_back(3);
      if (i <= 255) q_rr.push_back(8'(i));
      wait_st(1, 3, 300, "rx_reach_userrdy");
      wait_st(1, 1, 300, "rx_timeout_assert");
      if (i <= 3) chk("rx_retry_cnt", rx_retry, i);
      if (i == 2 || i == 3) chk("rx_retry_period", cyc - t_prev, 117);
      t_prev = cyc;
    end
    chk("rx_retry_saturated", rx_retry, 255);
    rxrd = 1'b1;
    q_rx.push_back(4);
    wait_st(1, 4, 50, "rx_done_after_retries");
    chk("rxdone_flag", rxdone, 1);
    chk("tx_still_done", tx_state, 4);
    // PLL loss
    q_tx.push_back(0);
    q_rx.push_back(0);
    qpll_lock = 1'b0;
    tick(3);
    chk("pll_loss_tx_idle", tx_state, 0);
    chk("pll_loss_rx_idle", rx_state, 0);
    chk("pll_loss_gttx", gttx, 1);
    chk("pll_loss_gtrx", gtrx, 1);
    chk("pll_loss_txu", txu, 0);
    chk("pll_loss_rxu", rxu, 0);
    chk("pll_loss_tx_retry", tx_retry, 0);
    chk("pll_loss_rx_retry", rx_retry, 255);
    tick(5);
    q_tx.push_back(1); q_tx.push_back(2); q_tx.push_back(3); q_tx.push_back(4);
    q_rx.push_back(1); q_rx.push_back(2); q_rx.push_back(3); q_rx.push_back(4);
    qpll_lock = 1'b1;
    wait_st(0, 4, 60, "relock_tx_done");
    wait_st(1, 4, 60, "relock_rx_done");
    // forced TX reset leaves RX alone
    q_tx.push_back(1);
    force_tx = 1'b1;
    tick(1);
    chk("force_gttx_next", gttx, 1);
    chk("force_tx_state", tx_state, 1);
    chk("force_txu", txu, 0);
    tick(39);
    chk("force_gttx_held", gttx, 1);
    chk("force_rx_state", rx_state, 4);
    chk("force_gtrx", gtrx, 0);
    chk("force_rxu", rxu, 1);
    chk("force_rxdone", rxdone, 1);
    q_tx.push_back(2); q_tx.push_back(3); q_tx.push_back(4);
    force_tx = 1'b0;
    n = 0;
    while (gttx === 1'b1 && n < 100) begin tick(1); n++; end
    chk("force_release_len", n, 16);
    wait_st(0, 4, 20, "force_tx_redone");
    chk("force_tx_retry", tx_retry, 0);
    chk("force_rx_retry", rx_retry, 255);
    // mid-operation reset while TX in USERRDY
    q_tx.push_back(1); q_tx.push_back(2); q_tx.push_back(3);
    txrd = 1'b0;
    wait_st(0, 3, 60, "tx_back_userrdy");
    q_tx.push_back(0);
    q_rx.push_back(0);
    q_rr.push_back(0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_gttx", gttx, 1);
    chk("mid_rst_gtrx", gtrx, 1);
    chk("mid_rst_txu", txu, 0);
    chk("mid_rst_rxu", rxu, 0);
    chk("mid_rst_tx_state", tx_state, 0);
    chk("mid_rst_rx_state", rx_state, 0);
    chk("mid_rst_txdone", txdone, 0);
    chk("mid_rst_rxdone", rxdone, 0);
    chk("mid_rst_tx_retry", tx_retry, 0);
    chk("mid_rst_rx_retry", rx_retry, 0);
    txrd = 1'b1;
    q_tx.push_back(1); q_tx.push_back(2); q_tx.push_back(3); q_tx.push_back(4);
    q_rx.push_back(1); q_rx.push_back(2); q_rx.push_back(3); q_rx.push_back(4);
    wait_st(0, 4, 60, "mid_rst_tx_redone");
    wait_st(1, 4, 60, "mid_rst_rx_redone");
    // CDR loss: one cycle short, then exactly the limit
    cdr = 1'b0;
    tick(1023);
    cdr = 1'b1;
    tick(10);
    chk("cdr_short_rx_state", rx_state, 4);
    chk("cdr_short_rx_retry", rx_retry, 0);
    chk("cdr_short_rxu", rxu, 1);
    q_rx.push_back(1); q_rx.push_back(2); q_rx.push_back(3); q_rx.push_back(4);
    q_rr.push_back(1);
    cdr = 1'b0;
    tick(1024);
    cdr = 1'b1;
    n = 0;
    while (rx_state !== 3'd1 && n < 10) begin tick(1); n++; end
    chk("cdr_loss_latency", n, 2);
    chk("cdr_loss_rx_retry", rx_retry, 1);
    chk("cdr_loss_gtrx", gtrx, 1);
    chk("cdr_loss_tx_state", tx_state, 4);
    wait_st(1, 4, 60, "cdr_rx_redone");
    tick(5);
    chk("tx_queue_drained", q_tx.size(), 0);
    chk("rx_queue_drained", q_rx.size(), 0);
    chk("rr_queue_drained", q_rr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
